cp0_multi_irq: RTL and testbench

CP0_MULTI_IRQ -- requirements
Module: cp0_multi_irq

---
 rtl/cp0_pkg.sv | 45 ++++
 rtl/cp0_timer.sv | 45 ++++
 rtl/cp0_multi_irq.sv | 134 +++++++++++++
 tb/tb_cp0_multi_irq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, Status/Cause field positions, exception codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   // Status field positions
   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_IM_LO = 8;

   // Cause field positions
   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;

   // Positions inside the 8-bit IP vector
   localparam int IP_SW_LO = 0;
   localparam int IP_HW_LO = 2;
   localparam int IP_TIMER = 7;

   // Exception codes
   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Architected Status state (everything else reads 0)
   typedef struct packed {
      logic [7:0] im;
      logic       exl;
      logic       ie;
   } status_t;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair with sticky timer-pending flag.
// Latency: Count advances every cycle; pending sets on the edge after Count==Compare.
// Backpressure: none; an MTC0 load of Count beats the increment, a Compare write beats a match.
module cp0_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_wr,
   input  logic             compare_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] compare,
   output logic             pending
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] compare_q, compare_d;
   logic             pend_q, pend_d;

   // Next-state: load-or-increment Count, load Compare, sticky match flag
   always_comb begin
      count_d   = count_wr ? wr_data : count_q + WIDTH'(1);
      compare_d = compare_wr ? wr_data : compare_q;
      pend_d    = compare_wr ? 1'b0 : (pend_q | (count_q == compare_q));
   end

   // Timer state; Compare resets to all ones so it does not fire right after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '1;
         pend_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign pending = pend_q;

endmodule

// File: rtl/cp0_multi_irq.sv
// CP0 Status/Cause/EPC with multi-line interrupts; optional Count/Compare under CP0_TIMER_EN.
// Latency: TakenInterrupt and rd_data combinational; register updates on the next edge.
// Backpressure: none; a take overrides same-cycle MTC0 (Status/Cause/EPC) and ERET.
module cp0_multi_irq
   import cp0_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_IRQ = 5
) (
   input  logic               clock,
   input  logic               reset,
   output logic [WIDTH-1:0]   rd_data,
   output logic [WIDTH-3:0]   EPC,
   output logic               TakenInterrupt,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic [4:0]         regnum,
   input  logic [WIDTH-3:0]   next_pc,
   input  logic [WIDTH-3:0]   cur_pc,
   input  logic               MTC0,
   input  logic               ERET,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               timer_irq,
   input  logic               exc_valid,
   input  logic [4:0]         exc_code
);

   status_t          status_q, status_d;
   logic [1:0]       sw_ip_q, sw_ip_d;
   logic [4:0]       exc_code_q, exc_code_d;
   logic [WIDTH-3:0] epc_q, epc_d;

   logic [WIDTH-1:0] count, compare;
   logic             timer_pend;
   logic [7:0]       ip;
   logic             take_exc, take_int;
   logic             unused_wr_bit;

   // wr_data[1] lands on read-only EXL, so it is never consumed
   assign unused_wr_bit = wr_data[1];

`ifdef CP0_TIMER_EN
   cp0_timer #(.WIDTH(WIDTH)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .count_wr   (MTC0 && (regnum == REG_COUNT)),
      .compare_wr (MTC0 && (regnum == REG_COMPARE)),
      .wr_data    (wr_data),
      .count      (count),
      .compare    (compare),
      .pending    (timer_pend)
   );
`else
   assign count      = '0;
   assign compare    = '0;
   assign timer_pend = 1'b0;
`endif

   // Assemble pending-interrupt vector: software, hardware lines, timer
   always_comb begin
      ip                       = '0;
      ip[IP_SW_LO +: 2]        = sw_ip_q;
      ip[IP_HW_LO +: NUM_IRQ]  = irq;
      ip[IP_TIMER]             = timer_pend | timer_irq;
   end

   assign take_exc       = exc_valid;
   assign take_int       = (|(ip & status_q.im)) & status_q.ie & ~status_q.exl & ~exc_valid;
   assign TakenInterrupt = take_exc | take_int;

   // Next-state: a take owns EXL/ExcCode/EPC, otherwise ERET and MTC0 apply
   always_comb begin
      status_d   = status_q;
      sw_ip_d    = sw_ip_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (TakenInterrupt) begin
         status_d.exl = 1'b1;
         exc_code_d   = take_exc ? exc_code : EXC_INT;
         // Nested take keeps the original resume point
         if (!status_q.exl) epc_d = take_exc ? cur_pc : next_pc;
      end else begin
         if (ERET) status_d.exl = 1'b0;
         if (MTC0) begin
            case (regnum)
               REG_STATUS: begin
                  status_d.im = wr_data[ST_IM_LO +: 8];
                  status_d.ie = wr_data[ST_IE];
               end
               REG_CAUSE: sw_ip_d = wr_data[CA_IP_LO +: 2];
               REG_EPC:   epc_d   = wr_data[WIDTH-1:2];
               default: ;
            endcase
         end
      end
   end

   // Architected CP0 state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status_q   <= '0;
         sw_ip_q    <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         status_q   <= status_d;
         sw_ip_q    <= sw_ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // Combinational read mux showing pre-edge register values
   always_comb begin
      rd_data = '0;
      case (regnum)
         REG_STATUS: begin
            rd_data[ST_IM_LO +: 8] = status_q.im;
            rd_data[ST_EXL]        = status_q.exl;
            rd_data[ST_IE]         = status_q.ie;
         end
         REG_CAUSE: begin
            rd_data[CA_IP_LO +: 8]  = ip;
            rd_data[CA_EXC_LO +: 5] = exc_code_q;
         end
         REG_EPC:     rd_data = {epc_q, 2'b00};
         REG_COUNT:   rd_data = count;
         REG_COMPARE: rd_data = compare;
         default: ;
      endcase
   end

   assign EPC = epc_q;

endmodule

// File: tb/tb_cp0_multi_irq.sv
// Randomized plus directed bench for cp0_multi_irq against a behavioural CP0 model.
// Latency: outputs sampled 2 time units after the falling edge, model advanced per rising edge.
// Backpressure: n/a.
module tb_cp0_multi_irq;

   logic        clock;
   logic        reset;
   logic [31:0] rd_data;
   logic [29:0] EPC;
   logic        TakenInterrupt;
   logic [31:0] wr_data;
   logic [4:0]  regnum;
   logic [29:0] next_pc;
   logic [29:0] cur_pc;
   logic        MTC0;
   logic        ERET;
   logic [4:0]  irq;
   logic        timer_irq;
   logic        exc_valid;
   logic [4:0]  exc_code;

   cp0_multi_irq #(.WIDTH(32), .NUM_IRQ(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .rd_data        (rd_data),
      .EPC            (EPC),
      .TakenInterrupt (TakenInterrupt),
      .wr_data        (wr_data),
      .regnum         (regnum),
      .next_pc        (next_pc),
      .cur_pc         (cur_pc),
      .MTC0           (MTC0),
      .ERET           (ERET),
      .irq            (irq),
      .timer_irq      (timer_irq),
      .exc_valid      (exc_valid),
      .exc_code       (exc_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural CP0 state
   logic [7:0]  m_im;
   logic        m_ie, m_exl;
   logic [1:0]  m_sw;
   logic [4:0]  m_code;
   logic [29:0] m_epc;
   logic [31:0] m_count, m_compare;
   logic        m_pend;

   // Values seen just before the rising edge in the latest step
   logic        obs_taken;
   logic [31:0] obs_rd;
   logic [29:0] obs_epc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_sw = '0; m_code = '0; m_epc = '0;
      m_count = '0; m_compare = 32'hFFFF_FFFF; m_pend = 1'b0;
   endtask

   function automatic logic [7:0] model_ip();
      logic [7:0] v;
      v = {6'b0, m_sw} | (8'(irq) << 2);
      v[7] = v[7] | m_pend | timer_irq;
      return v;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] rn, input logic [7:0] ip);
      case (rn)
         5'd12: return {16'h0, m_im, 6'h0, m_exl, m_ie};
         5'd13: return {16'h0, ip, 1'b0, m_code, 2'b00};
         5'd14: return {m_epc, 2'b00};
`ifdef CP0_TIMER_EN
         5'd9:  return m_count;
         5'd11: return m_compare;
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Compare outputs against the model, then advance the model across the coming edge
   task automatic eval_commit();
      logic [7:0] ip;
      logic       texc, tint, taken, hit;
      #2;
      ip    = model_ip();
      texc  = exc_valid;
      tint  = ((ip & m_im) != 8'h0) && m_ie && !m_exl && !exc_valid;
      taken = texc || tint;
      obs_taken = TakenInterrupt;
      obs_rd    = rd_data;
      obs_epc   = EPC;
      chk("taken", TakenInterrupt, taken);
      chk("rd_data", rd_data, model_read(regnum, ip));
      chk("epc", EPC, m_epc);
      if (taken) begin
         if (!m_exl) m_epc = texc ? cur_pc : next_pc;
         m_exl  = 1'b1;
         m_code = texc ? exc_code : 5'd0;
      end else begin
         if (ERET) m_exl = 1'b0;
         if (MTC0) begin
            case (regnum)
               5'd12: begin m_im = wr_data[15:8]; m_ie = wr_data[0]; end
               5'd13: m_sw  = wr_data[9:8];
               5'd14: m_epc = wr_data[31:2];
               default: ;
            endcase
         end
      end
`ifdef CP0_TIMER_EN
      hit = (m_count == m_compare);
      if (MTC0 && regnum == 5'd9) m_count = wr_data;
      else                        m_count = m_count + 32'd1;
      if (MTC0 && regnum == 5'd11) begin
         m_compare = wr_data;
         m_pend    = 1'b0;
      end else if (hit) begin
         m_pend = 1'b1;
      end
`else
      hit = 1'b0;
`endif
   endtask

   task automatic step(input bit mtc0_i, input logic [4:0] rn_i, input logic [31:0] wd_i,
                       input bit eret_i, input logic [4:0] irq_i, input bit tirq_i,
                       input bit exv_i, input logic [4:0] ec_i);
      @(negedge clock);
      MTC0 = mtc0_i; regnum = rn_i; wr_data = wd_i; ERET = eret_i;
      irq = irq_i; timer_irq = tirq_i; exc_valid = exv_i; exc_code = ec_i;
      next_pc = 30'($urandom); cur_pc = 30'($urandom);
      eval_commit();
   endtask

   task automatic idle_inputs();
      MTC0 = 1'b0; ERET = 1'b0; wr_data = '0; regnum = '0; irq = '0;
      timer_irq = 1'b0; exc_valid = 1'b0; exc_code = '0; next_pc = '0; cur_pc = '0;
   endtask

   // Reset across one rising edge, checking the reset view of every register
   task automatic do_reset();
      logic [4:0] rns [6];
      rns = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      @(negedge clock);
      reset = 1'b1;
      idle_inputs();
      #2;
      model_reset();
      chk("rst_taken", TakenInterrupt, 1'b0);
      chk("rst_epc", EPC, 30'h0);
      foreach (rns[i]) begin
         regnum = rns[i];
         #1;
         chk("rst_read", rd_data, model_read(regnum, model_ip()));
      end
      @(negedge clock);
      reset = 1'b0;
      regnum = '0;
      eval_commit();
   endtask

   task automatic random_cycles(input int n);
      logic [4:0]  rn_tab [7];
      logic [4:0]  irq_v, rn;
      logic [31:0] wd;
      bit          mt;
      irq_v = '0;
      for (int c = 0; c < n; c++) begin
         rn_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'($urandom)};
         rn = rn_tab[$urandom % 7];
         mt = ($urandom % 5) == 0;
         wd = $urandom;
         if (rn == 5'd12 && ($urandom % 2) == 1) wd[0] = 1'b1;
         if (rn == 5'd9 && ($urandom % 2) == 1) wd = m_compare - ($urandom % 4);
         if (($urandom % 8) == 0) irq_v = 5'($urandom);
         step(mt, rn, wd, ($urandom % 10) == 0, irq_v, ($urandom % 20) == 0,
              ($urandom % 15) == 0, 5'($urandom));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] sv_pc;
      bit          reached;
      reset = 1'b1;
      idle_inputs();
      do_reset();

      // Hardware interrupt on irq[0]
      step(1, 5'd12, 32'h0000_0401, 0, 5'd0, 0, 0, 5'd0);
      chk("irq_before_en", obs_taken, 1'b0);
      step(0, 5'd13, 32'h0, 0, 5'd1, 0, 0, 5'd0);
      chk("irq_take", obs_taken, 1'b1);
      chk("irq_cause_ip", obs_rd, 32'h0000_0400);
      sv_pc = next_pc;
      step(0, 5'd12, 32'h0, 0, 5'd1, 0, 0, 5'd0);
      chk("irq_no_retake", obs_taken, 1'b0);
      chk("irq_status_exl", obs_rd, 32'h0000_0403);
      chk("irq_epc_next_pc", obs_epc, sv_pc);
      step(0, 5'd13, 32'h0, 0, 5'd1, 0, 0, 5'd0);
      chk("irq_exccode0", obs_rd, 32'h0000_0400);

      // Exception while EXL is set: code updates, EPC holds
      step(0, 5'd13, 32'h0, 0, 5'd1, 0, 1, 5'd12);
      chk("nest_exc_take", obs_taken, 1'b1);
      step(0, 5'd13, 32'h0, 0, 5'd1, 0, 0, 5'd0);
      chk("nest_exccode", obs_rd, 32'h0000_0430);
      chk("nest_epc_hold", obs_epc, sv_pc);
      step(0, 5'd12, 32'h0, 1, 5'd1, 0, 0, 5'd0);
      step(0, 5'd12, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("eret_clears_exl", obs_rd, 32'h0000_0401);

      // Exception beats a pending enabled irq; MTC0 during a take is dropped
      step(1, 5'd12, 32'h0, 0, 5'd1, 0, 1, 5'd4);
      chk("exc_take", obs_taken, 1'b1);
      sv_pc = cur_pc;
      step(0, 5'd13, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("exc_epc_cur_pc", obs_epc, sv_pc);
      chk("exc_code", obs_rd, 32'h0000_0010);
      step(0, 5'd12, 32'h0, 1, 5'd0, 0, 0, 5'd0);
      chk("mtc0_drop_on_take", obs_rd, 32'h0000_0403);
      step(0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 5'd0);

      // External timer request via IP7
      do_reset();
      step(1, 5'd12, 32'h0000_8001, 0, 5'd0, 0, 0, 5'd0);
      step(0, 5'd9, 32'h0, 0, 5'd0, 1, 0, 5'd0);
      chk("timer_irq_take", obs_taken, 1'b1);
`ifndef CP0_TIMER_EN
      chk("no_timer_count_reads0", obs_rd, 32'h0);
      step(0, 5'd11, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("no_timer_compare_reads0", obs_rd, 32'h0);
`endif

`ifdef CP0_TIMER_EN
      // Count/Compare match, take, and clear on Compare write
      do_reset();
      step(1, 5'd11, 32'd5, 0, 5'd0, 0, 0, 5'd0);
      reached = 1'b0;
      for (int k = 0; k < 30 && !reached; k++) begin
         step(0, 5'd9, 32'h0, 0, 5'd0, 0, 0, 5'd0);
         if (obs_rd == 32'd6) reached = 1'b1;
      end
      chk("count_reaches_6", obs_rd, 32'd6);
      step(0, 5'd13, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("timer_pending", obs_rd[15], 1'b1);
      step(1, 5'd12, 32'h0000_8001, 0, 5'd0, 0, 0, 5'd0);
      step(0, 5'd13, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("timer_take", obs_taken, 1'b1);
      step(1, 5'd11, 32'd100, 0, 5'd0, 0, 0, 5'd0);
      step(0, 5'd13, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("compare_wr_clears", obs_rd[15], 1'b0);
      step(1, 5'd9, 32'hFFFF_FFFF, 0, 5'd0, 0, 0, 5'd0);
      step(0, 5'd9, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("count_max", obs_rd, 32'hFFFF_FFFF);
      step(0, 5'd9, 32'h0, 0, 5'd0, 0, 0, 5'd0);
      chk("count_wrap", obs_rd, 32'h0);
`endif

      // Random traffic
      do_reset();
      random_cycles(3000);

      // Reset asserted between edges while a take is in progress
      @(negedge clock);
      idle_inputs();
      exc_valid = 1'b1;
      exc_code  = 5'd8;
      regnum    = 5'd12;
      #2;
      chk("midtake_taken", TakenInterrupt, 1'b1);
      reset = 1'b1;
      #1;
      exc_valid = 1'b0;
      #1;
      model_reset();
      chk("midtake_status", rd_data, 32'h0);
      chk("midtake_epc", EPC, 30'h0);
      chk("midtake_taken_low", TakenInterrupt, 1'b0);
      regnum = 5'd13;
      #1;
      chk("midtake_cause", rd_data, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      regnum = 5'd11;
      eval_commit();
      random_cycles(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
